// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO pointer width, depth and the bin2gray/gray2bin helpers, which work on zero-extended vectors up to GW bits
package fifo_pkg;
  localparam int PTR_WIDTH = 3;
  localparam int DEPTH = 2 ** PTR_WIDTH;
  localparam int GW = 16;
  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b[GW-1] = g[GW-1];
    for (int i = GW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: W-bit two-flop synchronizer (clk, sync reset rst, async-domain d in, synchronized q out)
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1_q, s2_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end
  assign q = s2_q;
endmodule

// File: rtl/wptr_full.sv
// wptr_full: write-domain pointer/full logic (w_clk, w_rst, w_req, raw g_rptr in; w_en, b_wptr, g_wptr, full, almost_full, w_level, overflow out)
module wptr_full
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH = fifo_pkg::PTR_WIDTH,
  parameter int AF_LEVEL  = 6
) (
  input  logic               w_clk,
  input  logic               w_rst,
  input  logic               w_req,
  input  logic [PTR_WIDTH:0] g_rptr,
  output logic               w_en,
  output logic [PTR_WIDTH:0] b_wptr,
  output logic [PTR_WIDTH:0] g_wptr,
  output logic               full,
  output logic               almost_full,
  output logic [PTR_WIDTH:0] w_level,
  output logic               overflow
);
  localparam int PW = PTR_WIDTH + 1;
  localparam logic [PW-1:0] AF = PW'(AF_LEVEL);
  logic [PW-1:0] g_rptr_s, b_wptr_d, b_wptr_q, g_wptr_d, g_wptr_q, w_level_d, w_level_q;
  logic full_d, full_q, almost_full_d, almost_full_q, overflow_d, overflow_q;
  sync_2ff #(.W(PW)) u_sync (
    .clk(w_clk),
    .rst(w_rst),
    .d  (g_rptr),
    .q  (g_rptr_s)
  );
  always_comb begin
    w_en = w_req & ~full_q;
    b_wptr_d = b_wptr_q + PW'(w_en);
    g_wptr_d = PW'(bin2gray(GW'(b_wptr_d)));
    full_d = g_wptr_d == {~g_rptr_s[PW-1 -: 2], g_rptr_s[PW-3:0]};
    w_level_d = b_wptr_d - PW'(gray2bin(GW'(g_rptr_s)));
    almost_full_d = w_level_d >= AF;
    overflow_d = overflow_q | (w_req & full_q);
  end
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      b_wptr_q <= '0;
      g_wptr_q <= '0;
      full_q <= 1'b0;
      almost_full_q <= 1'b0;
      w_level_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      b_wptr_q <= b_wptr_d;
      g_wptr_q <= g_wptr_d;
      full_q <= full_d;
      almost_full_q <= almost_full_d;
      w_level_q <= w_level_d;
      overflow_q <= overflow_d;
    end
  end
  assign b_wptr = b_wptr_q;
  assign g_wptr = g_wptr_q;
  assign full = full_q;
  assign almost_full = almost_full_q;
  assign w_level = w_level_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_wptr_full.sv
// tb_wptr_full: directed and randomized checks of wptr_full against a write/read count model
module tb_wptr_full;
  logic w_clk = 1'b0;
  logic w_rst, w_req, w_en, full, almost_full, overflow;
  logic [3:0] g_rptr, b_wptr, g_wptr, w_level;
  int checks = 0, passes = 0;
  int wcnt = 0, rcnt = 0, m_level = 0;
  bit m_full = 0, m_af = 0, m_ovf = 0, wrapped = 0;
  int rq[$];
  logic [3:0] prev_g = '0, prev_b = '0;
  always #5 w_clk = ~w_clk;
  wptr_full #(.PTR_WIDTH(3), .AF_LEVEL(6)) dut (
    .w_clk      (w_clk),
    .w_rst      (w_rst),
    .w_req      (w_req),
    .g_rptr     (g_rptr),
    .w_en       (w_en),
    .b_wptr     (b_wptr),
    .g_wptr     (g_wptr),
    .full       (full),
    .almost_full(almost_full),
    .w_level    (w_level),
    .overflow   (overflow)
  );
  function automatic logic [3:0] gray(input int n);
    logic [3:0] b;
    b = 4'(n);
    return b ^ (b >> 1);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step(input bit req, input bit rd, input bit rst);
    bit acc;
    int rsync;
    @(negedge w_clk);
    w_rst = rst;
    w_req = req;
    if (rst) rcnt = 0;
    else if (rd) rcnt++;
    g_rptr = gray(rcnt);
    @(posedge w_clk);
    acc = 0;
    if (rst) begin
      wcnt = 0;
      m_ovf = 0;
      rq = '{0, 0};
      m_level = 0;
    end else begin
      acc = req && !m_full;
      if (req && m_full) m_ovf = 1;
      if (acc) wcnt++;
      rsync = rq.pop_front();
      rq.push_back(rcnt);
      m_level = wcnt - rsync;
    end
    m_full = m_level == 8;
    m_af = m_level >= 6;
    #1;
    chk("b_wptr", 32'(b_wptr), 32'(wcnt % 16));
    chk("g_wptr", 32'(g_wptr), 32'(gray(wcnt)));
    chk("full", 32'(full), 32'(m_full));
    chk("almost_full", 32'(almost_full), 32'(m_af));
    chk("w_level", 32'(w_level), 32'(m_level));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("w_en", 32'(w_en), 32'(req && !m_full));
    if (!rst) chk("gray_step", 32'($countones(g_wptr ^ prev_g)), 32'(acc));
    if (prev_b == 4'd15 && b_wptr == 4'd0) wrapped = 1;
    prev_g = g_wptr;
    prev_b = b_wptr;
  endtask
  initial begin
    w_rst = 1'b1;
    w_req = 1'b1;
    g_rptr = '0;
    rq = '{0, 0};
    step(1, 0, 1);
    step(1, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    chk("fill_gray", 32'(g_wptr), 32'h0000000c);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(w_level), 32'd8);
    step(1, 0, 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_ptr", 32'(b_wptr), 32'd8);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("drain_still_full", 32'(full), 32'd1);
    step(0, 0, 0);
    chk("drain_full", 32'(full), 32'd0);
    chk("drain_level", 32'(w_level), 32'd7);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("rst_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    step(1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("simul_level", 32'(w_level), 32'd5);
    chk("simul_af", 32'(almost_full), 32'd0);
    step(0, 0, 1);
    step(0, 0, 1);
    wrapped = 0;
    for (int i = 0; i < 400 && wcnt < 20; i++)
      step((wcnt - rcnt) < 4 && $urandom_range(0, 3) != 0, rcnt < wcnt && $urandom_range(0, 1) == 1, 0);
    chk("wrap_budget", 32'(wcnt >= 20), 32'd1);
    chk("wrap_seen", 32'(wrapped), 32'd1);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, rcnt < wcnt && $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
    step(1, 0, 1);
    chk("final_rst_ptr", 32'(b_wptr), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
